// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the data bits.
module uart_tx_fifo #(
   parameter int BAUD_DIV   = 10416,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_BITS-1:0]          in_data,
   output logic                          dout,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [PW:0] DEPTH     = (PW + 1)'(FIFO_DEPTH);
   localparam logic [PW:0] CNT_ONE   = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW:0]          count_q, count_d;
   state_t               state_q, state_d;
   logic [15:0]          baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 parity_q, parity_d;
   logic                 dout_q, dout_d;

   logic                 push;
   logic                 pop;
   logic                 tick;
   logic [DATA_BITS-1:0] head;

   assign in_ready   = (count_q < DEPTH);
   assign push       = in_valid && in_ready;
   assign head       = mem_q[rd_ptr_q];
   assign tick       = (baud_q == BAUD_LAST);
   assign dout       = dout_q;
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign fifo_count = count_q;

   // FIFO storage needs no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      parity_d = parity_q;
      pop      = 1'b0;
      dout_d   = 1'b1;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (tick) begin
               baud_d = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shreg_d = shreg_q >> 1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         PARITY: begin
            if (tick) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (tick) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // Chain straight into the next start bit so queued words leave with no idle gap.
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      if (pop) begin
         shreg_d  = head;
         parity_d = (^head) ^ PARITY_ODD;
      end

      // The line level is derived from the next state so dout stays a clean register.
      case (state_d)
         IDLE:    dout_d = 1'b1;
         START:   dout_d = 1'b0;
         DATA:    dout_d = shreg_d[0];
         PARITY:  dout_d = parity_q;
         STOP:    dout_d = 1'b1;
         default: dout_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         parity_q <= 1'b0;
         dout_q   <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         parity_q <= parity_d;
         dout_q   <= dout_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=4: 8N1 even, 7-data/2-stop, and odd-parity instances.
// Expected frames follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_fifo;

   localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA, rstB, rstC;
   logic       validA, validB, validC;
   logic [7:0] dataA, dataC;
   logic [6:0] dataB;
   logic       readyA, readyB, readyC;
   logic       doutA, doutB, doutC;
   logic       busyA, busyB, busyC;
   logic [2:0] countA, countB, countC;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1'b0)) dutA (
      .clk(clk), .rst(rstA), .in_valid(validA), .in_ready(readyA), .in_data(dataA),
      .dout(doutA), .busy(busyA), .fifo_count(countA));

   uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1'b0)) dutB (
      .clk(clk), .rst(rstB), .in_valid(validB), .in_ready(readyB), .in_data(dataB),
      .dout(doutB), .busy(busyB), .fifo_count(countB));

   uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1'b1)) dutC (
      .clk(clk), .rst(rstC), .in_valid(validC), .in_ready(readyC), .in_data(dataC),
      .dout(doutC), .busy(busyC), .fifo_count(countC));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic doutOf(input int sel);
      case (sel)
         0:       return doutA;
         1:       return doutB;
         default: return doutC;
      endcase
   endfunction

   // Offers one word for a single cycle; returns at the negedge after the accepting edge.
   task automatic applyStimulus(input int sel, input logic [7:0] w);
      @(negedge clk);
      case (sel)
         0:       begin validA = 1'b1; dataA = w;      end
         1:       begin validB = 1'b1; dataB = w[6:0]; end
         default: begin validC = 1'b1; dataC = w;      end
      endcase
      @(negedge clk);
      validA = 1'b0;
      validB = 1'b0;
      validC = 1'b0;
   endtask

   // seq holds the frame in transmission order, bit 0 first; each bit is held BD cycles.
   task automatic expectFrame(input int sel, input logic [15:0] seq, input int nbits, input string tag);
      for (int k = 0; k < nbits * BD; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s[%0d]", tag, k), {31'd0, doutOf(sel)}, {31'd0, seq[k / BD]});
      end
   endtask

   function automatic logic [15:0] makeFrame(input logic [7:0] w);
      logic [15:0] s;
      s    = '1;
      s[0] = 1'b0;
      for (int i = 0; i < 8; i++) s[i + 1] = w[i];
      if (P == 1) s[9] = ^w;
      return s;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] words [5];
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
      validA = 1'b0; validB = 1'b0; validC = 1'b0;
      dataA = '0; dataB = '0; dataC = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;

      $display("[TB] reset idle");
      repeat (100) begin
         @(negedge clk);
         checkOutput("idleA", {26'd0, doutA, readyA, busyA, countA}, 32'b110000);
      end
      checkOutput("idleB", {26'd0, doutB, readyB, busyB, countB}, 32'b110000);
      checkOutput("idleC", {26'd0, doutC, readyC, busyC, countC}, 32'b110000);

      $display("[TB] single word A5");
      applyStimulus(0, 8'hA5);
      checkOutput("pushCount", {29'd0, countA}, 32'd1);
      checkOutput("pushBusy", {31'd0, busyA}, 32'd1);
      checkOutput("pushDout", {31'd0, doutA}, 32'd1);
`ifdef UART_TX_PARITY_EN
      expectFrame(0, 16'b101_0100_1010, 11, "frameA5");
`else
      expectFrame(0, 16'b11_0100_1010, 10, "frameA5");
`endif
      @(negedge clk);
      checkOutput("a5DoneBusy", {31'd0, busyA}, 32'd0);
      checkOutput("a5DoneDout", {31'd0, doutA}, 32'd1);

      $display("[TB] back-to-back burst");
      @(negedge clk);
      validA = 1'b1;
      dataA  = words[0];
      fork
         begin
            for (int i = 1; i < 5; i++) begin
               @(negedge clk);
               dataA = words[i];
            end
            @(negedge clk);
            dataA = 8'h66;
            checkOutput("fullReady", {31'd0, readyA}, 32'd0);
            checkOutput("fullCount", {29'd0, countA}, 32'd4);
            repeat (3) begin
               @(negedge clk);
               checkOutput("holdCount", {29'd0, countA}, 32'd4);
            end
            validA = 1'b0;
         end
         begin
            @(posedge clk);
            @(posedge clk);
            for (int f = 0; f < 5; f++) begin
               expectFrame(0, makeFrame(words[f]), 10 + P, $sformatf("burst%0d", f));
            end
         end
      join
      @(negedge clk);
      checkOutput("burstBusy", {31'd0, busyA}, 32'd0);
      checkOutput("burstCount", {29'd0, countA}, 32'd0);

      $display("[TB] parity word 07");
      applyStimulus(0, 8'h07);
`ifdef UART_TX_PARITY_EN
      expectFrame(0, 16'b110_0000_1110, 11, "even07");
`else
      expectFrame(0, 16'b10_0000_1110, 10, "even07");
`endif
      applyStimulus(2, 8'h07);
`ifdef UART_TX_PARITY_EN
      expectFrame(2, 16'b100_0000_1110, 11, "odd07");
`else
      expectFrame(2, 16'b10_0000_1110, 10, "odd07");
`endif
      @(negedge clk);
      checkOutput("oddDoneBusy", {31'd0, busyC}, 32'd0);

      $display("[TB] 7 data bits, 2 stop bits");
      applyStimulus(1, 8'h41);
`ifdef UART_TX_PARITY_EN
      expectFrame(1, 16'b110_1000_0010, 11, "frame41");
`else
      expectFrame(1, 16'b11_1000_0010, 10, "frame41");
`endif
      @(negedge clk);
      checkOutput("b41DoneBusy", {31'd0, busyB}, 32'd0);

      $display("[TB] reset mid-frame");
      @(negedge clk);
      validA = 1'b1;
      dataA  = 8'h37;
      @(negedge clk);
      dataA = 8'h11;
      @(negedge clk);
      dataA = 8'h22;
      @(negedge clk);
      validA = 1'b0;
      checkOutput("queuedCount", {29'd0, countA}, 32'd2);
      repeat (16) @(negedge clk);
      checkOutput("dataBit3", {31'd0, doutA}, 32'd0);
      rstA = 1'b1;
      @(negedge clk);
      checkOutput("rstState", {26'd0, doutA, readyA, busyA, countA}, 32'b110000);
      rstA = 1'b0;
      repeat (60) begin
         @(negedge clk);
         checkOutput("afterRst", {30'd0, doutA, busyA}, 32'b10);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
